// File: rtl/imem_program_loader_pkg.sv
// Shared definitions for the instruction-memory loader: loader FSM state
// encodings, the supported MIPS opcode set and an opcode lookup helper.
// The opcode constants live here so the decoder and the loader share one list.
package imem_program_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_HI = 3'd1,
    ST_LEN_LO = 3'd2,
    ST_DATA   = 3'd3,
    ST_WRITE  = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERR    = 3'd6
  } loader_state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SUBI  = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_MOVE  = 6'h10;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SW    = 6'h2b;

  function automatic logic opcode_supported(input logic [5:0] op);
    logic ok;
    case (op)
      OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_SUBI, OP_SLTI,
      OP_ANDI, OP_ORI, OP_MOVE, OP_LB, OP_LW, OP_SB, OP_SW: ok = 1'b1;
      default:                                              ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/imem_opcode_checker.sv
// Combinational opcode screen used by the loader when LOADER_OPCODE_CHECK_EN
// is defined. The module only exists in builds that use it.
`ifdef LOADER_OPCODE_CHECK_EN
module imem_opcode_checker
  import imem_program_loader_pkg::*;
(
  input  logic [5:0] opcode,
  output logic       supported
);

  // Look the opcode up in the shared supported set.
  always_comb begin
    supported = opcode_supported(opcode);
  end

endmodule
`endif

// File: rtl/imem_program_loader.sv
// Instruction-memory loader: packs a length-prefixed host byte stream into
// 32-bit big-endian words and writes them to imem, holding the CPU until a
// complete program has landed.
// Optional build macro LOADER_OPCODE_CHECK_EN: screens every written word's
// opcode and ends the load in ERR (err_addr = first bad address) if any word
// was unsupported.
//
// state     | meaning
// ----------+-------------------------------------------------
// ST_IDLE   | after reset, waiting for start
// ST_LEN_HI | waiting for word-count high byte
// ST_LEN_LO | waiting for word-count low byte, range check
// ST_DATA   | collecting the 4 bytes of the current word
// ST_WRITE  | one-cycle imem write of the assembled word
// ST_DONE   | program loaded, CPU released
// ST_ERR    | load failed, CPU held
module imem_program_loader
  import imem_program_loader_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int MAX_WORDS = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] err_addr
);

  loader_state_e     state, state_nxt;
  logic [7:0]        len_hi;
  logic [15:0]       len_m1;
  logic [1:0]        byte_idx;
  logic [31:0]       word;
  logic [ADDR_W-1:0] word_cnt;
  logic [16:0]       len_full;
  logic              accept;
  logic              start_ok;
  logic              last_word;
  logic              word_bad;
  logic              opc_bad;

  assign accept    = in_valid & in_ready;
  assign start_ok  = start & ((state == ST_IDLE) | (state == ST_DONE) | (state == ST_ERR));
  assign len_full  = {1'b0, len_hi, in_data};
  // word_cnt stops at N-1 instead of stepping past it, so it can never wrap
  assign last_word = (16'(word_cnt) == len_m1);
  assign imem_addr  = word_cnt;
  assign imem_wdata = word;

`ifdef LOADER_OPCODE_CHECK_EN
  logic              opc_ok;
  logic [ADDR_W-1:0] err_addr_q;

  imem_opcode_checker u_opcode_checker (
    .opcode    (word[31:26]),
    .supported (opc_ok)
  );

  assign word_bad = ~opc_ok;
  assign err_addr = err_addr_q;

  // Sticky bad-opcode flag and first offending address, cleared per load.
  always_ff @(posedge clk) begin
    if (rst) begin
      opc_bad    <= 1'b0;
      err_addr_q <= '0;
    end else if (start_ok) begin
      opc_bad    <= 1'b0;
      err_addr_q <= '0;
    end else if ((state == ST_WRITE) && word_bad && !opc_bad) begin
      opc_bad    <= 1'b1;
      err_addr_q <= word_cnt;
    end
  end
`else
  assign word_bad = 1'b0;
  assign opc_bad  = 1'b0;
  assign err_addr = '0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode and state-derived outputs.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    imem_we   = 1'b0;
    cpu_hold  = 1'b1;
    busy      = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_LEN_HI;
      end
      ST_LEN_HI: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (accept) state_nxt = ST_LEN_LO;
      end
      ST_LEN_LO: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (accept) begin
          if (len_full == 17'd0)                 state_nxt = ST_DONE;
          else if (len_full > 17'(MAX_WORDS))    state_nxt = ST_ERR;
          else                                   state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (accept && (byte_idx == 2'd3)) state_nxt = ST_WRITE;
      end
      ST_WRITE: begin
        busy    = 1'b1;
        imem_we = 1'b1;
        if (last_word) state_nxt = (opc_bad | word_bad) ? ST_ERR : ST_DONE;
        else           state_nxt = ST_DATA;
      end
      ST_DONE: begin
        done     = 1'b1;
        cpu_hold = 1'b0;
        if (start) state_nxt = ST_LEN_HI;
      end
      ST_ERR: begin
        err = 1'b1;
        if (start) state_nxt = ST_LEN_HI;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Length capture, byte packing and word counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_hi   <= '0;
      len_m1   <= '0;
      byte_idx <= '0;
      word     <= '0;
      word_cnt <= '0;
    end else begin
      if (start_ok) begin
        byte_idx <= '0;
        word_cnt <= '0;
      end
      if (accept && (state == ST_LEN_HI)) len_hi <= in_data;
      if (accept && (state == ST_LEN_LO)) len_m1 <= len_full[15:0] - 16'd1;
      if (accept && (state == ST_DATA)) begin
        word     <= {word[23:0], in_data};
        byte_idx <= byte_idx + 2'd1;
      end
      if ((state == ST_WRITE) && !last_word) word_cnt <= word_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_imem_program_loader.sv
// Self-checking bench for imem_program_loader: table of programs applied in a
// loop, hand-written corner sequences, and a write scoreboard.
module tb_imem_program_loader;

`ifdef LOADER_OPCODE_CHECK_EN
  localparam bit OPC_EN = 1'b1;
`else
  localparam bit OPC_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        imem_we;
  logic [9:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        err;
  logic [9:0]  err_addr;

  imem_program_loader #(.ADDR_W(10), .MAX_WORDS(1024)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .err_addr   (err_addr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0]  addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    int          n;
    logic [31:0] w0, w1, w2;
    bit          rnd;
    bit          bad;
  } vec_t;

  wr_t  exp_q[$];
  vec_t vecs[5];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   e0;
  logic [9:0] exp_addr;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every imem write must match the oldest expected write.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", 32'(imem_addr), 32'hffffffff);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", 32'(imem_addr), 32'(e.addr));
        check("wr_data", imem_wdata, e.data);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick();
    start = 1'b0;
    e0 = cyc;
    exp_addr = '0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit rnd);
    bit acc = 1'b0;
    int guard = 0;
    while (!acc) begin
      if (rnd && ($urandom_range(0, 2) == 0)) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_data  = b;
      end
      @(negedge clk);
      acc = in_valid && in_ready;
      tick();
      guard++;
      if (!acc && guard > 60) begin
        check("byte_accept_timeout", 32'(guard), 32'd0);
        acc = 1'b1;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit rnd);
    exp_q.push_back('{addr: exp_addr, data: w});
    exp_addr = exp_addr + 10'd1;
    send_byte(w[31:24], rnd);
    send_byte(w[23:16], rnd);
    send_byte(w[15:8], rnd);
    send_byte(w[7:0], rnd);
  endtask

  task automatic wait_end;
    int k = 0;
    @(negedge clk);
    while (!(done === 1'b1 || err === 1'b1) && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) check("end_timeout", 32'(k), 32'd0);
  endtask

  task automatic run_vec(input int idx);
    logic [31:0] ws [3];
    bit exp_err;
    ws[0] = vecs[idx].w0;
    ws[1] = vecs[idx].w1;
    ws[2] = vecs[idx].w2;
    exp_err = vecs[idx].bad && OPC_EN;
    pulse_start();
    check("start_clears_done", 32'(done), 32'd0);
    check("start_clears_err", 32'(err), 32'd0);
    send_byte(8'(vecs[idx].n >> 8), vecs[idx].rnd);
    send_byte(8'(vecs[idx].n), vecs[idx].rnd);
    for (int i = 0; i < vecs[idx].n; i++) send_word(ws[i], vecs[idx].rnd);
    wait_end();
    if (!vecs[idx].rnd) check("load_cycles", 32'(cyc - e0), 32'(2 + 5 * vecs[idx].n));
    check("vec_done", 32'(done), 32'(!exp_err));
    check("vec_err", 32'(err), 32'(exp_err));
    check("vec_cpu_hold", 32'(cpu_hold), 32'(exp_err));
    check("vec_busy", 32'(busy), 32'd0);
    check("vec_in_ready", 32'(in_ready), 32'd0);
    check("vec_err_addr", 32'(err_addr), exp_err ? 32'd1 : 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    in_valid = 1'b0;
    in_data = 8'h00;
    exp_addr = '0;
    e0 = 0;

    vecs[0] = '{n: 2, w0: 32'h20010005, w1: 32'h00221820, w2: 32'h0,        rnd: 1'b0, bad: 1'b0};
    vecs[1] = '{n: 3, w0: 32'h8c220004, w1: 32'hac230008, w2: 32'h08000010, rnd: 1'b1, bad: 1'b0};
    vecs[2] = '{n: 1, w0: 32'h00000000, w1: 32'h0,        w2: 32'h0,        rnd: 1'b0, bad: 1'b0};
    vecs[3] = '{n: 3, w0: 32'h20010005, w1: 32'hfc000000, w2: 32'h00221820, rnd: 1'b0, bad: 1'b1};
    vecs[4] = '{n: 3, w0: 32'h0c000003, w1: 32'h10220002, w2: 32'h14220001, rnd: 1'b1, bad: 1'b0};

    repeat (3) tick();
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_imem_we", 32'(imem_we), 32'd0);
    check("rst_imem_addr", 32'(imem_addr), 32'd0);
    check("rst_imem_wdata", imem_wdata, 32'd0);
    check("rst_cpu_hold", 32'(cpu_hold), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_err_addr", 32'(err_addr), 32'd0);
    rst = 1'b0;

    // Byte offered in IDLE is not taken.
    in_valid = 1'b1;
    in_data = 8'h55;
    @(negedge clk);
    check("idle_in_ready", 32'(in_ready), 32'd0);
    tick();
    in_valid = 1'b0;

    for (int i = 0; i < 5; i++) run_vec(i);

    // N=0 straight to DONE, started from DONE.
    pulse_start();
    check("n0_done_dropped", 32'(done), 32'd0);
    check("n0_busy", 32'(busy), 32'd1);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    @(negedge clk);
    check("n0_done", 32'(done), 32'd1);
    check("n0_cpu_hold", 32'(cpu_hold), 32'd0);
    check("n0_no_write", 32'(exp_q.size()), 32'd0);

    // Byte offered in DONE is not taken.
    in_valid = 1'b1;
    in_data = 8'haa;
    @(negedge clk);
    check("done_in_ready", 32'(in_ready), 32'd0);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("done_held", 32'(done), 32'd1);

    // N=MAX_WORDS+1 rejected.
    pulse_start();
    send_byte(8'h04, 1'b0);
    send_byte(8'h01, 1'b0);
    @(negedge clk);
    check("ovf_err", 32'(err), 32'd1);
    check("ovf_cpu_hold", 32'(cpu_hold), 32'd1);
    check("ovf_in_ready", 32'(in_ready), 32'd0);
    check("ovf_err_addr", 32'(err_addr), 32'd0);
    check("ovf_busy", 32'(busy), 32'd0);

    // start pulse mid-DATA is ignored.
    pulse_start();
    send_byte(8'h00, 1'b1);
    send_byte(8'h02, 1'b1);
    exp_q.push_back('{addr: 10'd0, data: 32'h20010005});
    send_byte(8'h20, 1'b1);
    send_byte(8'h01, 1'b1);
    start = 1'b1;
    tick();
    start = 1'b0;
    @(negedge clk);
    check("mid_start_busy", 32'(busy), 32'd1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h05, 1'b1);
    exp_addr = 10'd1;
    send_word(32'h00221820, 1'b1);
    wait_end();
    check("mid_start_done", 32'(done), 32'd1);
    check("mid_start_err", 32'(err), 32'd0);

    // Reset after 6 bytes of an N=3 load.
    pulse_start();
    send_byte(8'h00, 1'b0);
    send_byte(8'h03, 1'b0);
    send_word(32'h8c220004, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rstmid_cpu_hold", 32'(cpu_hold), 32'd1);
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_done", 32'(done), 32'd0);
    check("rstmid_in_ready", 32'(in_ready), 32'd0);
    check("rstmid_writes", 32'(exp_q.size()), 32'd0);
    run_vec(0);

    // N=MAX_WORDS: last write lands at 1023.
    pulse_start();
    send_byte(8'h04, 1'b0);
    send_byte(8'h00, 1'b0);
    for (int i = 0; i < 1024; i++) send_word({6'h08, 26'(i)}, 1'b0);
    wait_end();
    check("max_cycles", 32'(cyc - e0), 32'(2 + 5 * 1024));
    check("max_done", 32'(done), 32'd1);
    check("max_err", 32'(err), 32'd0);

    repeat (2) tick();
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
